// File: rtl/key_cmd_queue.sv
// Purpose: queues debounced key pulses (up/down/left/right) as 2-bit command codes for the game FSM.
// Latency: a pulse sampled at edge E0 enqueues at E1, so cmd_valid rises 2 cycles after the pulse when not full.
// Backpressure: cmd_ready low holds the head entry; when full, pending keys wait and a repeated press merges (sets dropped).
//
// Ports:
//   clk, rst_n           system clock, synchronous active-low reset
//   uin/din/lin/rin      one-cycle key pulses from the debouncer
//   cmd_valid/cmd_ready  head-of-queue handshake toward the game logic
//   cmd_code             head command: 00 up, 01 down, 10 left, 11 right
//   level                entries currently stored, 0..DEPTH
//   dropped              sticky flag: a key press was merged into an already pending one
module key_cmd_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          uin,
  input  logic          din,
  input  logic          lin,
  input  logic          rin,
  output logic          cmd_valid,
  output logic [1:0]    cmd_code,
  input  logic          cmd_ready,
  output logic [AW:0]   level,
  output logic          dropped
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [3:0]    pulse;
  logic [3:0]    pending;
  logic [3:0]    grant;
  logic [1:0]    grant_code;
  logic          push;
  logic          pop;
  logic          full;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    mem [DEPTH];

  // Bit index doubles as the command code: 0 up, 1 down, 2 left, 3 right.
  assign pulse     = {rin, lin, din, uin};
  assign cmd_valid = (level != '0);
  assign full      = (level == FULL_LVL);
  assign pop       = cmd_valid & cmd_ready;
  // A pop frees a slot in the same cycle, so a full queue can still accept one key.
  assign push      = (pending != 4'b0000) & (~full | pop);
  assign cmd_code  = cmd_valid ? mem[rd_ptr] : 2'b00;

  // Fixed priority serialization of simultaneous presses: up > down > left > right.
  always_comb begin
    grant      = 4'b0000;
    grant_code = 2'd0;
    if (push) begin
      if (pending[0]) begin
        grant      = 4'b0001;
        grant_code = 2'd0;
      end else if (pending[1]) begin
        grant      = 4'b0010;
        grant_code = 2'd1;
      end else if (pending[2]) begin
        grant      = 4'b0100;
        grant_code = 2'd2;
      end else begin
        grant      = 4'b1000;
        grant_code = 2'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= 4'b0000;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      dropped <= 1'b0;
    end else begin
      // A new pulse on the bit being granted this cycle re-arms it (a second
      // code is queued later); on a bit that is waiting it is lost.
      pending <= (pending & ~grant) | pulse;
      if ((pulse & pending & ~grant) != 4'b0000)
        dropped <= 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Storage needs no reset: entries are only visible once level counts them.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= grant_code;
  end

endmodule

// File: tb/tb_key_cmd_queue.sv
module tb_key_cmd_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uin, din, lin, rin;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic [3:0] level;
  logic       dropped;

  int n_chk  = 0;
  int n_fail = 0;

  key_cmd_queue #(.DEPTH(8), .AW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uin       (uin),
    .din       (din),
    .lin       (lin),
    .rin       (rin),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_ready (cmd_ready),
    .level     (level),
    .dropped   (dropped)
  );

  always #5 clk = ~clk;

  // ins = {u, d, l, r, ready}, applied before an edge; the rest is the state after it.
  typedef struct packed {
    logic [4:0] ins;
    logic       v;
    logic [1:0] code;
    logic [3:0] lvl;
    logic       drp;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic u, input logic d, input logic l, input logic r, input logic rdy);
    uin = u; din = d; lin = l; rin = r; cmd_ready = rdy;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  int cnt01, cnt10;
  logic [1:0] last_code;

  initial begin
    // up pulse latency, simultaneous u/l/r, same-cycle re-press, merge
    tbl[0]  = '{5'b10000, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[1]  = '{5'b00000, 1'b1, 2'd0, 4'd1, 1'b0};
    tbl[2]  = '{5'b00000, 1'b1, 2'd0, 4'd1, 1'b0};
    tbl[3]  = '{5'b00001, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[4]  = '{5'b10110, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[5]  = '{5'b00000, 1'b1, 2'd0, 4'd1, 1'b0};
    tbl[6]  = '{5'b00000, 1'b1, 2'd0, 4'd2, 1'b0};
    tbl[7]  = '{5'b00000, 1'b1, 2'd0, 4'd3, 1'b0};
    tbl[8]  = '{5'b00000, 1'b1, 2'd0, 4'd3, 1'b0};
    tbl[9]  = '{5'b00001, 1'b1, 2'd2, 4'd2, 1'b0};
    tbl[10] = '{5'b00001, 1'b1, 2'd3, 4'd1, 1'b0};
    tbl[11] = '{5'b00001, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[12] = '{5'b00001, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[13] = '{5'b01000, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[14] = '{5'b01000, 1'b1, 2'd1, 4'd1, 1'b0};
    tbl[15] = '{5'b00000, 1'b1, 2'd1, 4'd2, 1'b0};
    tbl[16] = '{5'b00000, 1'b1, 2'd1, 4'd2, 1'b0};
    tbl[17] = '{5'b00001, 1'b1, 2'd1, 4'd1, 1'b0};
    tbl[18] = '{5'b00001, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[19] = '{5'b11000, 1'b0, 2'd0, 4'd0, 1'b0};
    tbl[20] = '{5'b01000, 1'b1, 2'd0, 4'd1, 1'b1};
    tbl[21] = '{5'b00000, 1'b1, 2'd0, 4'd2, 1'b1};
    tbl[22] = '{5'b00001, 1'b1, 2'd1, 4'd1, 1'b1};
    tbl[23] = '{5'b00001, 1'b0, 2'd0, 4'd0, 1'b1};

    // reset held with uin high must not capture the key
    rst_n = 1'b0; uin = 1'b1; din = 1'b0; lin = 1'b0; rin = 1'b0; cmd_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", {7'd0, cmd_valid}, 8'd0);
    chk("rst_level", {4'd0, level}, 8'd0);
    chk("rst_code", {6'd0, cmd_code}, 8'd0);
    rst_n = 1'b1; uin = 1'b0;
    tick();
    chk("post_rst_valid", {7'd0, cmd_valid}, 8'd0);
    chk("post_rst_level", {4'd0, level}, 8'd0);
    chk("post_rst_dropped", {7'd0, dropped}, 8'd0);

    for (int i = 0; i < 24; i++) begin
      step(tbl[i].ins[4], tbl[i].ins[3], tbl[i].ins[2], tbl[i].ins[1], tbl[i].ins[0]);
      chk($sformatf("vec%0d_valid", i), {7'd0, cmd_valid}, {7'd0, tbl[i].v});
      chk($sformatf("vec%0d_level", i), {4'd0, level}, {4'd0, tbl[i].lvl});
      chk($sformatf("vec%0d_dropped", i), {7'd0, dropped}, {7'd0, tbl[i].drp});
      if (tbl[i].v)
        chk($sformatf("vec%0d_code", i), {6'd0, cmd_code}, {6'd0, tbl[i].code});
    end

    // fill to DEPTH, overflow key waits, pop+push at full, drain; 3 rounds wrap the pointers
    do_reset();
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("fill_level", {4'd0, level}, 8'd8);
      idle(1);
      chk("full_hold_level", {4'd0, level}, 8'd8);
      chk("full_head_code", {6'd0, cmd_code}, 8'd1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("full_poppush_level", {4'd0, level}, 8'd8);
      for (int j = 0; j < 8; j++) begin
        chk($sformatf("wrap_r%0d_code%0d", rnd, j), {6'd0, cmd_code}, (j < 7) ? 8'd1 : 8'd3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      chk("drain_level", {4'd0, level}, 8'd0);
      chk("drain_valid", {7'd0, cmd_valid}, 8'd0);
    end
    chk("wrap_dropped", {7'd0, dropped}, 8'd0);

    // merge: second left press while the first is still pending on a full queue
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("merge_full_level", {4'd0, level}, 8'd8);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("merge_first_dropped", {7'd0, dropped}, 8'd0);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("merge_dropped", {7'd0, dropped}, 8'd1);
    chk("merge_level", {4'd0, level}, 8'd8);
    cnt01 = 0; cnt10 = 0; last_code = 2'd0;
    for (int j = 0; j < 12; j++) begin
      if (cmd_valid) begin
        if (cmd_code == 2'd1) cnt01++;
        if (cmd_code == 2'd2) cnt10++;
        last_code = cmd_code;
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    chk("merge_cnt10", cnt10[7:0], 8'd1);
    chk("merge_cnt01", cnt01[7:0], 8'd8);
    chk("merge_last_code", {6'd0, last_code}, 8'd2);
    chk("merge_end_level", {4'd0, level}, 8'd0);
    chk("merge_sticky", {7'd0, dropped}, 8'd1);

    // handshake stall: ready 1,0,1 at level 3
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("stall_level0", {4'd0, level}, 8'd3);
    chk("stall_code0", {6'd0, cmd_code}, 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("stall_level1", {4'd0, level}, 8'd2);
    chk("stall_code1", {6'd0, cmd_code}, 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall_level2", {4'd0, level}, 8'd2);
    chk("stall_code2", {6'd0, cmd_code}, 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("stall_level3", {4'd0, level}, 8'd1);
    chk("stall_code3", {6'd0, cmd_code}, 8'd2);

    // reset mid-operation: level 5 with down/left still pending
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(4);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("mid_level5", {4'd0, level}, 8'd5);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk("mid_rst_level", {4'd0, level}, 8'd0);
    chk("mid_rst_valid", {7'd0, cmd_valid}, 8'd0);
    chk("mid_rst_code", {6'd0, cmd_code}, 8'd0);
    idle(4);
    chk("mid_stale_level", {4'd0, level}, 8'd0);
    chk("mid_stale_valid", {7'd0, cmd_valid}, 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    chk("mid_fresh_level", {4'd0, level}, 8'd1);
    chk("mid_fresh_code", {6'd0, cmd_code}, 8'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mid_final_level", {4'd0, level}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_cmd_queue.md
Name: key_cmd_queue

Overview:
- Consumes the one-cycle key pulses (up/down/left/right) from the button debouncer.
- Buffers them in arrival order as 2-bit command codes in a small FIFO.
- Presents them to the Tetris game logic over a valid/ready handshake, so no key press is lost while the game FSM is busy (line clear, piece spawn).
- Simultaneous pulses are serialized in fixed priority order.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..16.
- AW, 3, pointer width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- uin  in  1  up pulse (rotate), one clk wide, from debouncer
- din  in  1  down pulse
- lin  in  1  left pulse
- rin  in  1  right pulse
- cmd_valid  out  1  head entry available
- cmd_code  out  2  head command: 00 up, 01 down, 10 left, 11 right
- cmd_ready  in  1  game logic accepts head this cycle
- level  out  AW+1  entries currently stored, 0..DEPTH
- dropped  out  1  sticky: at least one key press merged/lost since reset

Behaviour:
- Reset is the only clear. When rst_n=0 at a clk edge:
  - pending[3:0]=0, wr/rd pointers=0, level=0, cmd_valid=0, dropped=0.
  - cmd_code is don't-care while cmd_valid=0; the RTL drives 00.
  - Reset mid-operation discards all buffered and pending keys.
- Stage 1, pending latch:
  - Each edge, pending[k] <= (pending[k] & ~grant[k]) | pulse[k].
  - Bit order: k=0 up, 1 down, 2 left, 3 right.
- Stage 2, enqueue:
  - push = (pending!=0) & (level<DEPTH | pop).
  - grant = lowest-index set pending bit, one-hot: up>down>left>right.
  - On push: write code k at wr_ptr, wr_ptr+1 with wrap mod DEPTH, clear pending[k].
  - Pending bits not granted persist. Each is enqueued one per cycle on later edges.
- Latency: pulse sampled at edge E0 sets pending; enqueue at E1; cmd_valid=1 after E1, i.e. 2 cycles pulse-to-valid when the FIFO is not full.
- Dequeue:
  - pop = cmd_valid & cmd_ready. On pop: rd_ptr+1, wrap mod DEPTH.
  - cmd_code = mem[rd_ptr], registered/stable while cmd_valid=1 and no pop.
  - cmd_ready while cmd_valid=0 is ignored.
- Level:
  - level += push - pop; push and pop in the same cycle leave level unchanged.
  - cmd_valid = (level!=0).
- Full:
  - level==DEPTH and no pop → no push; pending bits hold.
  - Full with pop in the same cycle → push allowed, level stays DEPTH.
- Merge/drop: a pulse[k] arriving while pending[k]=1 and grant[k]=0 merges into the existing bit. That press is lost, so dropped <= 1 (sticky).
- Pulse for k in the same cycle as grant[k]: pending[k] stays 1, no drop; a second code k is queued later.
- Empty with no pending: cmd_valid=0, pointers static.
- Pointer wrap: mem index uses AW bits. level is tracked separately, so full/empty are never ambiguous.

Test Plan:
- Reset: hold rst_n=0 with uin=1 → after release, cmd_valid=0, level=0, dropped=0. Pulse uin for 1 cycle → cmd_valid=1 exactly 2 edges later, cmd_code=00, level=1.
- Simultaneous: uin=rin=lin=1 for one cycle, cmd_ready=0 → level increments 1,2,3 over 3 consecutive edges. Then cmd_ready=1 → codes pop as 00,10,11, then cmd_valid=0.
- Fill/wrap: DEPTH=8. Queue 8 din pulses with cmd_ready=0 → level=8. A 9th rin pulse stays pending, level=8. Assert cmd_ready for 1 cycle → 01 popped, 11 enqueued the same edge, level stays 8. Drain all 8 → order 01×7 then 11. Repeat 3 rounds to exercise pointer wrap.
- Merge: FIFO full, lin pulsed twice 4 cycles apart → dropped=1, only one 10 is enqueued after space frees.
- Handshake stall: level=3, cmd_ready toggled 1,0,1 → exactly 2 pops, cmd_code constant during the stall cycle, level 3→2→2→1.
- Reset mid-operation: level=5 with 2 pending bits, rst_n=0 for one edge → level=0, cmd_valid=0, and no stale codes appear afterwards.
